// File: rtl/uart_frame_counter_pkg.sv
// Shared UART frame definitions: frame constants, data-bit encoding and
// the frame-length helper also used by the shift register.
package uart_pkg;

    localparam logic [3:0] UART_START_BITS = 4'd1;
    localparam logic [3:0] UART_MIN_DATA   = 4'd5;
    localparam logic [3:0] UART_MAX_FRAME  = 4'd12;

    typedef enum logic [1:0] {
        DATA_5 = 2'd0,
        DATA_6 = 2'd1,
        DATA_7 = 2'd2,
        DATA_8 = 2'd3
    } uart_data_bits_e;

    // Start + data + optional parity + stop bits; always 7..12.
    function automatic logic [3:0] uart_frame_len(
        input logic [1:0] data_bits,
        input logic       parity_en,
        input logic       stop2
    );
        logic [3:0] w_stop;
        w_stop = stop2 ? 4'd2 : 4'd1;
        return UART_START_BITS + UART_MIN_DATA + {2'b00, data_bits}
               + {3'b000, parity_en} + w_stop;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter producing the one-cycle bit-time-up strobe; optionally
// shortens the first period of a frame to half for mid-bit sampling.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 19
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_doit,
    input  logic [DIV_W-1:0] i_div_q,
    input  logic             i_half_first,
    output logic             o_btu
);

    logic [DIV_W-1:0] r_bt_cnt;
    logic             r_first;
    logic [DIV_W-1:0] w_limit;
    logic             w_hit;

    assign w_limit = (i_half_first && r_first) ? (i_div_q >> 1) : i_div_q;
    assign w_hit   = (r_bt_cnt == w_limit);
    // Gated by reset so the strobe is low while state is being cleared.
    assign o_btu   = i_doit & ~i_reset & w_hit;

    // Bit-time counter and first-period flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bt_cnt <= {DIV_W{1'b0}};
            r_first  <= 1'b1;
        end else if (!i_doit) begin
            r_bt_cnt <= {DIV_W{1'b0}};
            r_first  <= 1'b1;
        end else if (w_hit) begin
            r_bt_cnt <= {DIV_W{1'b0}};
            r_first  <= 1'b0;
        end else begin
            r_bt_cnt <= r_bt_cnt + DIV_W'(1);
            r_first  <= r_first;
        end
    end

endmodule

// File: rtl/uart_frame_counter.sv
// UART bit/frame counter: config latch, saturating bit counter and done flag.
// Optional feature: define UART_FRAME_RX_MID_EN to add rx_mode (half first period).
module uart_frame_counter
    import uart_pkg::*;
#(
    parameter int DIV_W = 19,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             doit,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
`ifdef UART_FRAME_RX_MID_EN
    input  logic             rx_mode,
`endif
    output logic             btu,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] frame_len,
    output logic             done
);

    logic [CNT_W-1:0] r_frame_len;
    logic [DIV_W-1:0] r_div_q;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_btu;
    logic             w_half_first;
`ifdef UART_FRAME_RX_MID_EN
    logic             r_rx_mode;
    assign w_half_first = r_rx_mode;
`else
    assign w_half_first = 1'b0;
`endif

    // Config follows the inputs while idle and is frozen for the whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_len <= {CNT_W{1'b0}};
            r_div_q     <= {DIV_W{1'b0}};
`ifdef UART_FRAME_RX_MID_EN
            r_rx_mode   <= 1'b0;
`endif
        end else if (!doit) begin
            r_frame_len <= CNT_W'(uart_frame_len(data_bits, parity_en, stop2));
            r_div_q     <= baud_div;
`ifdef UART_FRAME_RX_MID_EN
            r_rx_mode   <= rx_mode;
`endif
        end else begin
            r_frame_len <= r_frame_len;
            r_div_q     <= r_div_q;
`ifdef UART_FRAME_RX_MID_EN
            r_rx_mode   <= r_rx_mode;
`endif
        end
    end

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_doit       (doit),
        .i_div_q      (r_div_q),
        .i_half_first (w_half_first),
        .o_btu        (w_btu)
    );

    // Bit counter saturates at the frame length; btu keeps pulsing after that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= {CNT_W{1'b0}};
        end else if (!doit) begin
            r_bit_cnt <= {CNT_W{1'b0}};
        end else if (w_btu && (r_bit_cnt < r_frame_len)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign btu       = w_btu;
    assign bit_cnt   = r_bit_cnt;
    assign frame_len = r_frame_len;
    assign done      = doit & ~reset & (r_bit_cnt == r_frame_len);

endmodule

// File: tb/tb_uart_frame_counter.sv
// Self-checking bench for uart_frame_counter: frame-length table, hand-written
// corner sequences and randomized frames against an arithmetic reference model.
module tb_uart_frame_counter;

    localparam int DIV_W = 19;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             doit;
    logic [DIV_W-1:0] baud_div;
    logic [1:0]       data_bits;
    logic             parity_en;
    logic             stop2;
`ifdef UART_FRAME_RX_MID_EN
    logic             rx_mode;
`endif
    logic             btu;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] frame_len;
    logic             done;

    int total = 0;
    int bad   = 0;

    // next-cycle inputs, previous-cycle inputs, and model state
    int n_reset, n_doit, n_baud, n_db, n_pe, n_s2, n_rx;
    int p_reset, p_doit, p_baud, p_db, p_pe, p_s2, p_rx;
    int m_N, m_D, m_rx, m_run;

    uart_frame_counter #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .doit      (doit),
        .baud_div  (baud_div),
        .data_bits (data_bits),
        .parity_en (parity_en),
        .stop2     (stop2),
`ifdef UART_FRAME_RX_MID_EN
        .rx_mode   (rx_mode),
`endif
        .btu       (btu),
        .bit_cnt   (bit_cnt),
        .frame_len (frame_len),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int db;
        int pe;
        int s2;
        int exp_len;
    } len_vec_t;

    len_vec_t lv [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Number of btu strobes within the first n high cycles of a frame.
    function automatic int btus_in(input int n, input int d, input int rx);
        int first;
        first = rx ? (d / 2) + 1 : d + 1;
        if (n < first) return 0;
        return 1 + (n - first) / (d + 1);
    endfunction

    task automatic step();
        int c0, c1, e_bc, e_btu, e_done, e_fl;
        @(posedge clk);
        if (p_reset != 0) begin
            m_N = 0; m_D = 0; m_rx = 0; m_run = 0;
        end else if (p_doit == 0) begin
            m_N   = 1 + (p_db + 5) + p_pe + (p_s2 != 0 ? 2 : 1);
            m_D   = p_baud;
            m_rx  = p_rx;
            m_run = 0;
        end else begin
            m_run++;
        end
        #1;
        reset     = (n_reset != 0);
        doit      = (n_doit != 0);
        baud_div  = DIV_W'(n_baud);
        data_bits = 2'(n_db);
        parity_en = (n_pe != 0);
        stop2     = (n_s2 != 0);
`ifdef UART_FRAME_RX_MID_EN
        rx_mode   = (n_rx != 0);
`endif
        p_reset = n_reset; p_doit = n_doit; p_baud = n_baud;
        p_db = n_db; p_pe = n_pe; p_s2 = n_s2; p_rx = n_rx;
        #1;
        if (n_reset != 0) begin
            e_btu = 0; e_bc = 0; e_done = 0; e_fl = 0;
        end else begin
            c0     = btus_in(m_run, m_D, m_rx);
            c1     = btus_in(m_run + 1, m_D, m_rx);
            e_bc   = (c0 < m_N) ? c0 : m_N;
            e_btu  = (n_doit != 0 && c1 != c0) ? 1 : 0;
            e_done = (n_doit != 0 && e_bc == m_N) ? 1 : 0;
            e_fl   = m_N;
        end
        chk("model_btu", int'(btu), e_btu);
        chk("model_bit_cnt", int'(bit_cnt), e_bc);
        chk("model_done", int'(done), e_done);
        chk("model_frame_len", int'(frame_len), e_fl);
    endtask

    task automatic set_cfg(input int baud, input int db, input int pe, input int s2);
        n_baud = baud; n_db = db; n_pe = pe; n_s2 = s2;
    endtask

    initial begin
        lv[0] = '{0, 0, 0, 7};
        lv[1] = '{3, 0, 0, 10};
        lv[2] = '{0, 1, 1, 9};
        lv[3] = '{3, 1, 1, 12};
        lv[4] = '{1, 1, 0, 9};
        lv[5] = '{2, 0, 1, 10};

        n_rx = 0;
        p_reset = 1; p_doit = 0; p_baud = 0; p_db = 0; p_pe = 0; p_s2 = 0; p_rx = 0;
        m_N = 0; m_D = 0; m_rx = 0; m_run = 0;
        reset = 1'b1; doit = 1'b1; baud_div = '0; data_bits = 2'd0;
        parity_en = 1'b0; stop2 = 1'b0;
`ifdef UART_FRAME_RX_MID_EN
        rx_mode = 1'b0;
`endif

        // reset held with doit high, then release with doit still high
        n_reset = 1; n_doit = 1; set_cfg(9, 3, 0, 0);
        repeat (3) step();
        chk("rst_btu", int'(btu), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_done", int'(done), 0);
        n_reset = 0;
        repeat (2) step();
        chk("rst_no_latch", int'(frame_len), 0);

        // 8N1, divisor 9: btu every 10 cycles, done at cycle 101
        n_doit = 0; step();
        n_doit = 1;
        for (int t = 1; t <= 101; t++) begin
            step();
            if (t <= 100) chk("seq1_btu", int'(btu), (t % 10 == 0) ? 1 : 0);
            if (t == 100) chk("seq1_done_early", int'(done), 0);
        end
        chk("seq1_done", int'(done), 1);
        chk("seq1_bit_cnt", int'(bit_cnt), 10);
        chk("seq1_frame_len", int'(frame_len), 10);

        // 5 data, parity, 2 stop, divisor 0: btu every cycle, saturate at 9
        n_doit = 0; set_cfg(0, 0, 1, 1); step();
        n_doit = 1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t <= 9) chk("seq2_btu", int'(btu), 1);
            if (t == 9) chk("seq2_done_early", int'(done), 0);
        end
        chk("seq2_frame_len", int'(frame_len), 9);
        chk("seq2_bit_cnt_sat", int'(bit_cnt), 9);
        chk("seq2_done", int'(done), 1);

        // config change mid-frame is ignored until doit drops
        n_doit = 0; set_cfg(3, 3, 0, 0); step();
        n_doit = 1;
        repeat (12) step();
        chk("seq3_third_btu", int'(btu), 1);
        n_db = 0;
        repeat (5) step();
        chk("seq3_frozen", int'(frame_len), 10);
        n_doit = 0; step();
        n_doit = 1; step();
        chk("seq3_relatched", int'(frame_len), 7);

        // doit low on the 4th btu cycle, then high again right after
        n_doit = 0; set_cfg(3, 3, 0, 0); step();
        n_doit = 1;
        repeat (15) step();
        n_doit = 0; step();
        chk("seq4_no_btu_low", int'(btu), 0);
        n_doit = 1; step();
        chk("seq4_cnt_cleared", int'(bit_cnt), 0);
        chk("seq4_restart_btu1", int'(btu), 0);
        repeat (2) step();
        chk("seq4_restart_btu3", int'(btu), 0);
        step();
        chk("seq4_restart_btu4", int'(btu), 1);

        // reset asserted mid-frame
        n_doit = 0; set_cfg(2, 3, 0, 0); step();
        n_doit = 1; repeat (10) step();
        n_reset = 1; step();
        chk("seq5_btu", int'(btu), 0);
        chk("seq5_bit_cnt", int'(bit_cnt), 0);
        chk("seq5_frame_len", int'(frame_len), 0);
        chk("seq5_done", int'(done), 0);
        n_reset = 0; n_doit = 0; set_cfg(2, 0, 0, 0); step();
        n_doit = 1; step();
        chk("seq5_relatch", int'(frame_len), 7);

        // frame-length table
        for (int i = 0; i < 6; i++) begin
            n_doit = 0; set_cfg(1, lv[i].db, lv[i].pe, lv[i].s2); step();
            n_doit = 1; step();
            chk("tbl_frame_len", int'(frame_len), lv[i].exp_len);
        end

`ifdef UART_FRAME_RX_MID_EN
        // receive mode: first btu mid start bit, then every 16 cycles
        n_doit = 0; n_rx = 1; set_cfg(15, 3, 0, 0); step();
        n_doit = 1;
        for (int t = 1; t <= 153; t++) begin
            step();
            if (t <= 152) chk("rx_btu", int'(btu), (t >= 8 && (t - 8) % 16 == 0) ? 1 : 0);
        end
        chk("rx_done", int'(done), 1);
        n_rx = 0;
`endif

        // randomized frames with mid-frame noise
        for (int f = 0; f < 30; f++) begin
            int len;
            n_reset = 0; n_doit = 0;
            set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1));
`ifdef UART_FRAME_RX_MID_EN
            n_rx = $urandom_range(0, 1);
`endif
            step();
            len = $urandom_range(5, 100);
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 9) == 0) n_db = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) n_baud = $urandom_range(0, 6);
                n_reset = ($urandom_range(0, 60) == 0) ? 1 : 0;
                n_doit  = ($urandom_range(0, 40) == 0) ? 0 : 1;
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_counter.md
# uart_frame_counter

Parametrised bit-time and bit counter for the UART transmit and receive paths. It generates the bit-time-up (BTU) strobe from a programmable baud divisor. It counts bits against a runtime-configurable frame length covering 5–8 data bits, optional parity and 1 or 2 stop bits, and flags frame completion. It sits between the UART control FSM, which drives `doit`, and the shift register, which consumes `btu` and `bit_cnt`. It replaces the fixed 11-bit counter.

## Interface
- `DIV_W`, default 19: width of the baud divisor and the bit-time counter.
- `CNT_W`, default 4: width of the bit counter. Must hold the maximum frame length of 12.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous and active-high, clears all state.
- `doit`  in  1  level enable; high for the whole frame, low clears both counters.
- `baud_div`  in  DIV_W  bit period minus one, in `clk` cycles.
- `data_bits`  in  2  data bit count minus 5 (0 = 5 bits … 3 = 8 bits).
- `parity_en`  in  1  frame includes a parity bit.
- `stop2`  in  1  frame has two stop bits instead of one.
- `btu`  out  1  one-cycle bit-time-up strobe.
- `bit_cnt`  out  CNT_W  number of bit periods completed in the current frame.
- `frame_len`  out  CNT_W  latched frame length N.
- `done`  out  1  level; high while `bit_cnt == frame_len`.
- `rx_mode`  in  1  present only with `UART_FRAME_RX_MID_EN`; see Configuration.

## Operation
- Frame length: N = 1 + (data_bits + 5) + parity_en + (stop2 ? 2 : 1). The range is 7..12.
- Config latch: `frame_len`, the divisor copy and `rx_mode` load on every edge where `doit` = 0. They are frozen on every edge where `doit` = 1. Config changes mid-frame have no effect until `doit` drops.
- Bit-time counter `bt_cnt`, states:
  - `doit` = 0: `bt_cnt` ← 0.
  - `doit` = 1 and `bt_cnt == div_q`: `bt_cnt` ← 0.
  - Otherwise: `bt_cnt` ← `bt_cnt` + 1.
- `btu` = `doit` & (`bt_cnt == div_q`). It is decoded from registers and `doit` only.
- Bit counter:
  - `doit` = 0: `bit_cnt` ← 0.
  - `doit` & `btu` & (`bit_cnt` < `frame_len`): `bit_cnt` ← `bit_cnt` + 1.
  - Otherwise: hold.
  - Saturates at N; it never wraps.
- `done` = (`bit_cnt == frame_len`) & `doit`.
- `btu` keeps pulsing after `done`. Consumers must ignore it.
- A `baud_div` of 0 gives `btu` every cycle while `doit` is high. The minimum frame time is then N cycles.

## Timing
- Reset values: `bt_cnt` = 0, `bit_cnt` = 0, `frame_len` = 0, div copy = 0, `btu` = 0, `done` = 0.
- The first `btu` occurs `baud_div` + 1 cycles after the first cycle `doit` is high. Later `btu` pulses are spaced `baud_div` + 1 cycles apart.
- `bit_cnt` increments on the edge that ends a `btu` cycle. `done` rises in the cycle after the N-th `btu`.
- `doit` falling at any point, including mid-bit or on a `btu` cycle: both counters are 0 on the next edge. No `btu` is issued while `doit` is low.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronous clear). Operation resumes on the first edge after release, with config relatched while `doit` is low.
- `doit` re-asserted in the cycle right after a drop: a full new frame starts from 0.

## Configuration
- `UART_FRAME_RX_MID_EN` defined:
  - Adds the `rx_mode` input.
  - When latched `rx_mode` = 1, the first bit period of a frame uses limit `div_q >> 1`. The first `btu` therefore lands mid start bit; later periods use `div_q`.
  - With `rx_mode` = 1, `done` means the stop-bit sample point.
- Not defined:
  - No `rx_mode` port.
  - Every period uses `div_q`, i.e. transmit-only behaviour.

## Structure
- Shared package `uart_pkg`:
  - Frame constants: `UART_START_BITS` = 1, `UART_MIN_DATA` = 5, `UART_MAX_FRAME` = 12.
  - The `data_bits` encoding.
  - A `uart_frame_len` function computing N, reused by the shift register.
- One sub-module, `uart_baud_tick`: owns `bt_cnt`, the half-period first-bit logic and `btu`.
- The top level owns the config latch, the bit counter and `done`.

## Test plan
- Reset with `doit` = 1 → `btu` = 0, `bit_cnt` = 0, `done` = 0. After release, config is not latched until `doit` is first low.
- `baud_div` = 9, data_bits = 3 (8 data), parity off, 1 stop, `doit` held → `btu` at cycles 10, 20, …, 100. `done` rises at cycle 101 with `bit_cnt` = 10.
- data_bits = 0 (5 data), parity on, 2 stop, `baud_div` = 0 → `frame_len` = 9, `btu` every cycle, `done` after 9 cycles. `bit_cnt` saturates at 9 with `doit` still high.
- Change `data_bits` from 3 to 0 after the 3rd `btu` → `frame_len` stays 10. After `doit` low then high, `frame_len` = 7.
- Drop `doit` on the cycle of the 4th `btu` → next cycle `bit_cnt` = 0, `bt_cnt` = 0, no further `btu`.
- With `UART_FRAME_RX_MID_EN`, `rx_mode` = 1, `baud_div` = 15, 8N1 → first `btu` at cycle 8, then every 16 cycles. `done` after the 10th `btu`.
